key_sel_debounce: RTL and testbench

//   Front end for the 4:1 LED mux lab. Takes the two raw active-low push-buttons (key1, key2),

---
 rtl/key_sel_debounce.sv | 75 +++++++
 tb/tb_key_sel_debounce.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_sel_debounce.sv
// key_sel_debounce: front end for the 4:1 LED mux lab.
// Two active-low push-buttons are synchronised and debounced. Each clean press
// produces a one-cycle pulse and toggles one bit of the registered mux select.
// The two channels are identical and independent, and there is no arbitration.
// Every output is a flop, so no combinational path runs from key1/key2 to an output.

module key_sel_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000,   // 20 ms at 12 MHz, must be >= 2
    parameter int CNT_W           = 18        // 2**CNT_W >= DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1,
    input  logic       key2,
    output logic [1:0] key_db,
    output logic [1:0] press,
    output logic [1:0] sel
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [CNT_W-1:0] cnt [2];

    assign raw = {key2, key1};

    // Two-flop synchroniser. It resets to "released" so that no spurious press follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce each channel. A level is accepted after DEBOUNCE_CYCLES consecutive
    // samples that differ from the current level. Any sample at the accepted level
    // restarts the count, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_db <= 2'b11;
            press  <= 2'b00;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == key_db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    key_db[i] <= sync2[i];
                    cnt[i]    <= '0;
                    // Only the falling edge (press) pulses. A release is silent.
                    press[i]  <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Select toggles one edge after the press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= 2'b00;
        end else begin
            sel <= sel ^ press;
        end
    end

endmodule

// File: tb/tb_key_sel_debounce.sv
// Bench for key_sel_debounce with DEBOUNCE_CYCLES=8. It runs directed scenarios
// followed by randomized bouncy key activity. The reference model works on a
// sample history: a channel accepts a new level once the last D synchronised
// samples all disagree with the current level.

module tb_key_sel_debounce;

    localparam int D = 8;

    logic       clk;
    logic       rst;
    logic       key1;
    logic       key2;
    logic [1:0] key_db;
    logic [1:0] press;
    logic [1:0] sel;

    int total = 0;
    int bad   = 0;
    int p0_cnt = 0;
    int p0_snap;

    key_sel_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key1  (key1),
        .key2  (key2),
        .key_db(key_db),
        .press (press),
        .sel   (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. hist[0] holds the raw keys seen at the latest edge.
    // hist[2] is what the synchroniser presents at that edge.
    logic [1:0] hist [0:D+1];
    logic [1:0] m_db;
    logic [1:0] m_press;
    logic [1:0] m_sel;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= D + 1; k++) hist[k] = 2'b11;
            m_db    = 2'b11;
            m_press = 2'b00;
            m_sel   = 2'b00;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {key2, key1};
            m_sel   = m_sel ^ m_press;
            m_press = 2'b00;
            for (int i = 0; i < 2; i++) begin
                bit all_new;
                all_new = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (hist[k][i] == m_db[i]) all_new = 1'b0;
                if (all_new) begin
                    m_db[i]    = hist[2][i];
                    m_press[i] = ~hist[2][i];
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("key_db", 32'(key_db), 32'(m_db));
            chk("press",  32'(press),  32'(m_press));
            chk("sel",    32'(sel),    32'(m_sel));
            if (press[0] === 1'b1) p0_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
    endtask

    initial begin
        key1 = 1'b1;
        key2 = 1'b1;
        rst  = 1'b1;

        // Reset for two edges, then hold idle.
        cycles(2);
        rst = 1'b0;
        cycles(50);
        chk("t1_key_db", 32'(key_db), 32'h3);
        chk("t1_sel",    32'(sel),    32'h0);

        // Clean press and release of key1.
        key1 = 1'b0;
        cycles(20);
        chk("t2_sel_pressed", 32'(sel), 32'h1);
        key1 = 1'b1;
        cycles(20);
        chk("t2_sel_released", 32'(sel), 32'h1);

        // Bounce shorter than the debounce window is rejected.
        key1 = 1'b0; cycles(7);
        key1 = 1'b1; cycles(1);
        key1 = 1'b0; cycles(7);
        key1 = 1'b1; cycles(20);
        chk("t3_sel",    32'(sel),    32'h1);
        chk("t3_key_db", 32'(key_db), 32'h3);

        // Simultaneous presses from a fresh reset.
        pulse_rst();
        key1 = 1'b0; key2 = 1'b0; cycles(20);
        chk("t4_sel_first", 32'(sel), 32'h3);
        key1 = 1'b1; key2 = 1'b1; cycles(20);
        key1 = 1'b0; key2 = 1'b0; cycles(20);
        chk("t4_sel_second", 32'(sel), 32'h0);
        key1 = 1'b1; key2 = 1'b1; cycles(20);

        // Reset in the middle of a key2 debounce. The key stays held through the reset.
        key2 = 1'b0;
        cycles(7);
        pulse_rst();
        cycles(20);
        chk("t5_sel", 32'(sel), 32'h2);
        key2 = 1'b1;
        cycles(20);

        // Long hold of key1 gives a single pulse.
        p0_snap = p0_cnt;
        key1 = 1'b0;
        cycles(1000);
        key1 = 1'b1;
        cycles(20);
        chk("t6_pulses", 32'(p0_cnt - p0_snap), 32'd1);
        chk("t6_sel",    32'(sel),              32'h3);

        // Randomized bouncy activity with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(39) == 0) begin
                pulse_rst();
            end else begin
                key1 = 1'($urandom_range(1));
                key2 = 1'($urandom_range(1));
                cycles(int'($urandom_range(14, 1)));
            end
        end
        key1 = 1'b1;
        key2 = 1'b1;
        cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
